max_pool_2x2: RTL and testbench

Streaming 2×2 max-pooling stage between the convolution datapath and the VGA threshold/display stage. Consumes the 124×164 unsigned convolution map in raster order and writes the 62×82 pooled map into an internal pool RAM. Tracks the global maximum `max_pl` and exposes a registered random-access read port (`rd_en`/`rd_addr`/`rd_data`) that the display stage scans after `done`.

---
 rtl/max_pool_2x2_pkg.sv | 18 +
 rtl/max_pool_2x2_if.sv | 34 +++
 rtl/max_pool_2x2_pool_ram.sv | 40 ++++
 rtl/max_pool_2x2.sv | 153 +++++++++++++++
 tb/tb_max_pool_2x2.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/max_pool_2x2_pkg.sv
// Shared CNN constants and types used by the pooling stage and the display stage.
// Contents: sample width, pooled map geometry, pool RAM depth/address width and the
// pooling FSM state type.
package cnn_pkg;

    localparam int unsigned DW         = 20;
    localparam int unsigned POOL_W     = 62;
    localparam int unsigned POOL_H     = 82;
    localparam int unsigned POOL_DEPTH = POOL_W * POOL_H;
    localparam int unsigned AW         = 13;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } pool_state_e;

endpackage

// File: rtl/max_pool_2x2_if.sv
// Bus bundle for max_pool_2x2.
// Signals:
//   start    - begin a new frame (taken only when idle or done)
//   in_valid - in_data valid this cycle, no backpressure
//   in_data  - convolution sample, raster order
//   rd_en    - pool RAM read strobe
//   rd_addr  - pool RAM read address (prow * POOL_W + pcol)
//   rd_data  - registered read data
//   max_pl   - running maximum of pooled values this frame
//   done     - frame complete
// Modports: master drives the frame and reads, slave is the pooling block.
interface max_pool_2x2_if #(
    parameter int unsigned DW = cnn_pkg::DW,
    parameter int unsigned AW = cnn_pkg::AW
);
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] max_pl;
    logic          done;

    modport master (
        output start, in_valid, in_data, rd_en, rd_addr,
        input  rd_data, max_pl, done
    );

    modport slave (
        input  start, in_valid, in_data, rd_en, rd_addr,
        output rd_data, max_pl, done
    );
endinterface

// File: rtl/max_pool_2x2_pool_ram.sv
// Simple dual-port pool RAM: one synchronous write port and one registered
// read-first read port. Addresses at or beyond DEPTH read back as 0.
// Ports:
//   clk, rst          - clock, synchronous active-high reset (clears rd_data only)
//   we/wr_addr/wr_data - write port
//   rd_en/rd_addr      - read request, data appears on rd_data after the edge
//   rd_data            - registered read data, holds while rd_en is low
module pool_ram #(
    parameter int unsigned DEPTH = cnn_pkg::POOL_DEPTH,
    parameter int unsigned DW    = cnn_pkg::DW,
    parameter int unsigned AW    = cnn_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the array gives read-first behaviour on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (rd_addr <= LAST_ADDR) ? mem[rd_addr] : '0;
        end
    end
endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 max-pooling stage. Consumes an IN_W x IN_H raster-order map,
// writes the (IN_W/2) x (IN_H/2) pooled map into pool_ram and tracks the frame
// maximum. The display stage reads the RAM through the rd_* port after done.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   bus - max_pool_2x2_if slave (start, in_valid, in_data, rd_en, rd_addr,
//         rd_data, max_pl, done)
module max_pool_2x2 #(
    parameter int unsigned IN_W = 124,
    parameter int unsigned IN_H = 164,
    parameter int unsigned DW   = cnn_pkg::DW,
    parameter int unsigned AW   = cnn_pkg::AW
) (
    input logic           clk,
    input logic           rst,
    max_pool_2x2_if.slave bus
);
    localparam int unsigned HALF_W = IN_W / 2;
    localparam int unsigned POOL_N = HALF_W * (IN_H / 2);
    localparam int unsigned CW     = $clog2(IN_W);
    localparam int unsigned RW     = $clog2(IN_H);

    cnn_pkg::pool_state_e state_q, state_d;

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [DW-1:0] pair_q;
    logic [DW-1:0] max_pl_q;
    logic [DW-1:0] line_buf [HALF_W];

    // Window result staged one cycle before it reaches the RAM and max_pl.
    logic          wr_en_q;
    logic          wr_last_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;

    logic          accept;
    logic          start_ok;
    logic          col_last;
    logic          row_last;
    logic [CW-2:0] half_col;
    logic [DW-1:0] pm;
    logic [DW-1:0] lb_rd;
    logic [DW-1:0] wm;
    logic [AW-1:0] win_addr;

    assign accept   = bus.in_valid && (state_q == cnn_pkg::StFill);
    assign start_ok = bus.start && (state_q != cnn_pkg::StFill);
    assign col_last = (col_q == CW'(IN_W - 1));
    assign row_last = (row_q == RW'(IN_H - 1));
    assign half_col = col_q[CW-1:1];
    assign pm       = (bus.in_data > pair_q) ? bus.in_data : pair_q;
    assign lb_rd    = line_buf[half_col];
    assign wm       = (pm > lb_rd) ? pm : lb_rd;
    assign win_addr = AW'(row_q[RW-1:1]) * AW'(HALF_W) + AW'(half_col);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= cnn_pkg::StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            cnn_pkg::StIdle,
            cnn_pkg::StDone: if (bus.start) state_d = cnn_pkg::StFill;
            // Leave FILL on the edge that commits the final window.
            cnn_pkg::StFill: if (wr_en_q && wr_last_q) state_d = cnn_pkg::StDone;
            default:         state_d = cnn_pkg::StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.done   = (state_q == cnn_pkg::StDone);
        bus.max_pl = max_pl_q;
    end

    // Counters, pair register, window staging and running maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            pair_q    <= '0;
            max_pl_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_last_q <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            wr_last_q <= 1'b0;
            if (start_ok) begin
                col_q    <= '0;
                row_q    <= '0;
                pair_q   <= '0;
                max_pl_q <= '0;
            end else begin
                if (wr_en_q && (wr_data_q > max_pl_q)) begin
                    max_pl_q <= wr_data_q;
                end
                if (accept) begin
                    if (!col_q[0]) begin
                        pair_q <= bus.in_data;
                    end else if (row_q[0]) begin
                        wr_en_q   <= 1'b1;
                        wr_last_q <= row_last && col_last;
                    end
                    if (col_last) begin
                        col_q <= '0;
                        row_q <= row_last ? '0 : row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
            end
        end
    end

    // Data-only staging registers; wr_en_q qualifies them.
    always_ff @(posedge clk) begin
        if (accept && col_q[0] && row_q[0]) begin
            wr_addr_q <= win_addr;
            wr_data_q <= wm;
        end
    end

    // Line buffer holds the even-row pair maxima for the following odd row.
    always_ff @(posedge clk) begin
        if (!rst && accept && col_q[0] && !row_q[0]) begin
            line_buf[half_col] <= pm;
        end
    end

    pool_ram #(
        .DEPTH (POOL_N),
        .DW    (DW),
        .AW    (AW)
    ) u_pool_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en_q),
        .wr_addr (wr_addr_q),
        .wr_data (wr_data_q),
        .rd_en   (bus.rd_en),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data)
    );
endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2: ramp, random-with-gaps, mid-frame reset
// and single-spike frames, each compared against a 2x2 window reference model.
module tb_max_pool_2x2;
    localparam int unsigned IN_W   = 124;
    localparam int unsigned IN_H   = 164;
    localparam int unsigned N_IN   = IN_W * IN_H;
    localparam int unsigned PW     = IN_W / 2;
    localparam int unsigned PH     = IN_H / 2;
    localparam int unsigned N_POOL = PW * PH;
    localparam int unsigned DW     = 20;
    localparam int unsigned AW     = 13;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    max_pool_2x2_if #(.DW(DW), .AW(AW)) bus ();

    max_pool_2x2 #(
        .IN_W (IN_W),
        .IN_H (IN_H),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] frame    [N_IN];
    logic [DW-1:0] pool_ref [N_POOL];
    logic [DW-1:0] max_ref;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: each pooled entry is the maximum of its 2x2 input window.
    function automatic void build_ref();
        max_ref = '0;
        for (int pr = 0; pr < int'(PH); pr++) begin
            for (int pc = 0; pc < int'(PW); pc++) begin
                logic [DW-1:0] m;
                m = '0;
                for (int dr = 0; dr < 2; dr++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        logic [DW-1:0] v;
                        v = frame[(2 * pr + dr) * IN_W + 2 * pc + dc];
                        if (v > m) m = v;
                    end
                end
                pool_ref[pr * PW + pc] = m;
                if (m > max_ref) max_ref = m;
            end
        end
    endfunction

    // kind 0: ramp, 1: single spike at (7,10), 2: random
    function automatic void make_frame(input int kind);
        for (int i = 0; i < int'(N_IN); i++) begin
            case (kind)
                0:       frame[i] = DW'(i);
                1:       frame[i] = '0;
                default: frame[i] = ($urandom_range(0, 49) == 0) ? {DW{1'b1}} : DW'($urandom);
            endcase
        end
        if (kind == 1) frame[7 * IN_W + 10] = 20'hFFFFF;
        build_ref();
    endfunction

    task automatic start_frame(input string tag);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_eq({tag, "_start_done"}, {31'd0, bus.done}, 32'd0);
        check_eq({tag, "_start_max"}, {12'd0, bus.max_pl}, 32'd0);
    endtask

    // Feed the frame with in_valid present valid_pct% of cycles; stops before
    // sample stop_at (if >= 0) and pulses start alongside sample start_at.
    task automatic feed(input int valid_pct, input int stop_at, input int start_at);
        for (int i = 0; i < int'(N_IN); i++) begin
            if (i == stop_at) break;
            while ($urandom_range(0, 99) >= valid_pct) begin
                bus.in_valid = 1'b0;
                bus.in_data  = DW'($urandom);
                step();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = frame[i];
            bus.start    = (i == start_at);
            step();
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    // Called right after the edge that accepted the last sample.
    task automatic finish_check(input string tag);
        check_eq({tag, "_done_at_last"}, {31'd0, bus.done}, 32'd0);
        step();
        check_eq({tag, "_done_next"}, {31'd0, bus.done}, 32'd1);
        check_eq({tag, "_max_pl"}, {12'd0, bus.max_pl}, {12'd0, max_ref});
    endtask

    task automatic read_one(input string tag, input int addr, input logic [DW-1:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(addr);
        step();
        bus.rd_en = 1'b0;
        check_eq(tag, {12'd0, bus.rd_data}, {12'd0, exp});
    endtask

    // Back-to-back reads, one per cycle.
    task automatic dump(input string tag, input int stride);
        for (int k = 0; k < int'(N_POOL); k += stride) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = AW'(k);
            step();
            check_eq($sformatf("%s[%0d]", tag, k), {12'd0, bus.rd_data}, {12'd0, pool_ref[k]});
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic junk_valid(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        step();
        step();
        check_eq("reset_done", {31'd0, bus.done}, 32'd0);
        check_eq("reset_max_pl", {12'd0, bus.max_pl}, 32'd0);
        check_eq("reset_rd_data", {12'd0, bus.rd_data}, 32'd0);
        rst = 1'b0;

        // in_valid while idle must not move the counters.
        junk_valid(7);
        check_eq("idle_done", {31'd0, bus.done}, 32'd0);

        // Frame A: ramp, continuous, stray start mid-frame.
        make_frame(0);
        start_frame("ramp");
        feed(100, -1, 5000);
        finish_check("ramp");
        check_eq("ramp_max_const", {12'd0, bus.max_pl}, 32'd20335);
        junk_valid(9);
        check_eq("done_hold_done", {31'd0, bus.done}, 32'd1);
        check_eq("done_hold_max", {12'd0, bus.max_pl}, 32'd20335);
        read_one("rd_addr0", 0, DW'(1 * 124 + 1));
        read_one("rd_addr100", 100, DW'((2 * 1 + 1) * 124 + 2 * 38 + 1));
        read_one("rd_addr5084", 5084, '0);
        read_one("rd_addr8191", 8191, '0);
        read_one("rd_addr5083", 5083, DW'((2 * 81 + 1) * 124 + 2 * 61 + 1));
        bus.rd_addr = '0;
        step();
        step();
        check_eq("rd_hold", {12'd0, bus.rd_data}, {12'd0, pool_ref[5083]});
        dump("ramp_pool", 7);

        // Frame B: random data, ~2/3 in_valid duty, started from DONE.
        make_frame(2);
        start_frame("rand");
        feed(67, -1, 9000);
        finish_check("rand");
        dump("rand_pool", 1);

        // Frame C: aborted by reset after 3000 samples.
        make_frame(2);
        start_frame("abort");
        feed(100, 3000, -1);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("rst_mid_done", {31'd0, bus.done}, 32'd0);
        check_eq("rst_mid_max", {12'd0, bus.max_pl}, 32'd0);
        check_eq("rst_mid_rd", {12'd0, bus.rd_data}, 32'd0);
        junk_valid(5);
        check_eq("rst_idle_max", {12'd0, bus.max_pl}, 32'd0);

        // Frame D: single spike after the reset.
        make_frame(1);
        start_frame("spike");
        feed(100, -1, -1);
        finish_check("spike");
        check_eq("spike_max_const", {12'd0, bus.max_pl}, 32'hFFFFF);
        read_one("spike_entry", 3 * 62 + 5, 20'hFFFFF);
        dump("spike_pool", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
